// File: rtl/mouse_packet_decoder.sv
`timescale 1ns/1ps
// mouse_packet_decoder: assembles 3-byte PS/2 mouse packets from the receiver's
// validated byte stream. It decodes buttons and signed deltas and keeps a
// clamped cursor position. After a framing error, a misaligned byte 0 or an
// inter-byte timeout it goes back to waiting for byte 0.
module mouse_packet_decoder #(
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int POS_W          = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    input  logic             frame_err,
    output logic             pkt_valid,
    output logic             btn_left,
    output logic             btn_right,
    output logic             btn_middle,
    output logic [8:0]       dx,
    output logic [8:0]       dy,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             sync_err,
    output logic             timeout
);

    // Two guard bits: the sum of a POS_W-bit position and a 9-bit delta
    // always fits, so the clamp sees the true value and never a wrapped one.
    localparam int SUM_W = POS_W + 2;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [SUM_W-1:0] X_LIM    = SUM_W'(X_MAX);
    localparam logic signed [SUM_W-1:0] Y_LIM    = SUM_W'(Y_MAX);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

    state_t           state, state_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic             cap_b0, cap_b1, dec_vld_p0;
    logic             sync_err_next, timeout_next;
    logic [7:0]       b0_p0, b1_p0;

    logic signed [8:0]       dx_new, dy_new;
    logic signed [SUM_W-1:0] x_sum, y_sum;

    // Sign-extend a 9-bit delta to the guarded position width.
    function automatic logic signed [SUM_W-1:0] sext_delta(input logic signed [8:0] d);
        return SUM_W'(d);
    endfunction

    // Saturate a guarded signed position into the range 0..lim.
    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [SUM_W-1:0] v,
                                                   input logic signed [SUM_W-1:0] lim);
        logic [POS_W-1:0] r;
        if (v[SUM_W-1])
            r = '0;
        else if (v > lim)
            r = lim[POS_W-1:0];
        else
            r = v[POS_W-1:0];
        return r;
    endfunction

    // State and inter-byte timer registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= WAIT_B0;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Next-state logic. frame_err overrides everything; a byte beats the timeout.
    always_comb begin
        state_next    = state;
        timer_next    = timer;
        cap_b0        = 1'b0;
        cap_b1        = 1'b0;
        dec_vld_p0    = 1'b0;
        sync_err_next = 1'b0;
        timeout_next  = 1'b0;
        if (frame_err) begin
            state_next = WAIT_B0;
            timer_next = '0;
        end else begin
            case (state)
                WAIT_B0: begin
                    timer_next = '0;
                    if (byte_valid) begin
                        if (byte_data[3]) begin
                            cap_b0     = 1'b1;
                            state_next = WAIT_B1;
                        end else begin
                            sync_err_next = 1'b1;
                        end
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    if (byte_valid) begin
                        timer_next = '0;
                        if (state == WAIT_B1) begin
                            cap_b1     = 1'b1;
                            state_next = WAIT_B2;
                        end else begin
                            dec_vld_p0 = 1'b1;
                            state_next = WAIT_B0;
                        end
                    end else if (timer == TMR_LAST) begin
                        timer_next   = '0;
                        timeout_next = 1'b1;
                        state_next   = WAIT_B0;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
                default: begin
                    state_next = WAIT_B0;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Capture bytes 0 and 1. Byte 2 is decoded straight from byte_data.
    always_ff @(posedge Clk) begin
        if (cap_b0) b0_p0 <= byte_data;
        if (cap_b1) b1_p0 <= byte_data;
    end

    // Decode the deltas (an overflow flag zeroes its axis) and the new positions.
    always_comb begin
        dx_new = b0_p0[6] ? 9'sd0 : $signed({b0_p0[4], b1_p0});
        dy_new = b0_p0[7] ? 9'sd0 : $signed({b0_p0[5], byte_data});
        x_sum  = $signed({2'b00, x_pos}) + sext_delta(dx_new);
        y_sum  = $signed({2'b00, y_pos}) - sext_delta(dy_new);
    end

    // ---- stage p0 -> outputs: status strobes and decoded packet ----
    // Strobes are one-cycle pulses. Decoded fields update together with pkt_valid.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pkt_valid  <= 1'b0;
            sync_err   <= 1'b0;
            timeout    <= 1'b0;
            btn_left   <= 1'b0;
            btn_right  <= 1'b0;
            btn_middle <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            x_pos      <= POS_W'(X_MAX / 2);
            y_pos      <= POS_W'(Y_MAX / 2);
        end else begin
            pkt_valid <= dec_vld_p0;
            sync_err  <= sync_err_next;
            timeout   <= timeout_next;
            if (dec_vld_p0) begin
                btn_left   <= b0_p0[0];
                btn_right  <= b0_p0[1];
                btn_middle <= b0_p0[2];
                dx         <= dx_new;
                dy         <= dy_new;
                x_pos      <= clamp_pos(x_sum, X_LIM);
                y_pos      <= clamp_pos(y_sum, Y_LIM);
            end
        end
    end

endmodule
